// File: rtl/aes_seq_pkg.sv
// Shared types, Rcon table and lookup helper for the AES round sequencer.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WHITEN = 3'd1,
        ST_KEYEXP = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } aes_seq_state_t;

    typedef enum logic [1:0] {
        OP_WHITEN = 2'd0,
        OP_KEYEXP = 2'd1,
        OP_ROUND  = 2'd2
    } aes_op_kind_t;

    localparam int unsigned RCON_ENTRIES = 11;

    // Entry 0 is unused by key expansion and reads as zero.
    localparam logic [7:0] RCON_TABLE [RCON_ENTRIES] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (32'(idx) < RCON_ENTRIES) r = RCON_TABLE[idx];
        return r;
    endfunction

endpackage

// File: rtl/aes_rcon_rom.sv
// Combinational round index -> Rcon byte lookup.
module aes_rcon_rom
    import aes_seq_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       rcon_c
);

    // Out-of-table indices fall back to zero inside rcon_of.
    always_comb rcon_c = rcon_of(4'(idx));

endmodule

// File: rtl/aes_round_sequencer.sv
// Issues the WHITEN / KEYEXP / ROUND micro-op stream for one AES-128 pass.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             decrypt,
    input  logic             abort,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_kind,
    output logic [IDX_W-1:0] round_idx,
    output logic [7:0]       rcon,
    output logic             key_assist,
    output logic             encryption,
    output logic             final_round,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    aes_seq_state_t   state, state_n;
    logic [IDX_W-1:0] cnt, cnt_n;
    logic             dir, dir_n;
    logic             fire;
    logic [7:0]       rcon_c;

    logic             valid_n, key_assist_n, enc_n, final_n, busy_n, done_n;
    aes_op_kind_t     kind_n;
    logic [7:0]       rcon_n;

    aes_rcon_rom #(.IDX_W(IDX_W)) u_rcon_rom (
        .idx    (cnt_n),
        .rcon_c (rcon_c)
    );

    // Next state / counter / direction; abort overrides any fire outside IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        fire    = op_valid && op_ready;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    dir_n   = decrypt;
                    state_n = decrypt ? ST_KEYEXP : ST_WHITEN;
                    cnt_n   = decrypt ? ONE : '0;
                end
            end
            ST_WHITEN: begin
                if (fire) begin
                    state_n = dir ? ST_ROUND : ST_KEYEXP;
                    cnt_n   = dir ? cnt - ONE : cnt + ONE;
                end
            end
            ST_KEYEXP: begin
                if (fire) begin
                    if (!dir) begin
                        state_n = ST_ROUND;
                    end else if (cnt == LAST) begin
                        state_n = ST_WHITEN;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            ST_ROUND: begin
                if (fire) begin
                    if (cnt == (dir ? '0 : LAST)) begin
                        state_n = ST_DONE;
                        cnt_n   = '0;
                    end else if (dir) begin
                        cnt_n = cnt - ONE;
                    end else begin
                        state_n = ST_KEYEXP;
                        cnt_n   = cnt + ONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end
    end

    // Output values for the next cycle, decoded from next state and counter.
    always_comb begin
        valid_n      = (state_n == ST_WHITEN) || (state_n == ST_KEYEXP) || (state_n == ST_ROUND);
        key_assist_n = (state_n == ST_KEYEXP);
        busy_n       = (state_n != ST_IDLE);
        done_n       = (state_n == ST_DONE);
        enc_n        = busy_n && !dir_n;
        final_n      = (state_n == ST_ROUND) && (cnt_n == (dir_n ? '0 : LAST));
        rcon_n       = key_assist_n ? rcon_c : 8'h00;
        kind_n       = OP_WHITEN;
        if (state_n == ST_KEYEXP) kind_n = OP_KEYEXP;
        if (state_n == ST_ROUND)  kind_n = OP_ROUND;
    end

    // State, counter, direction and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            dir         <= 1'b0;
            op_valid    <= 1'b0;
            op_kind     <= 2'd0;
            round_idx   <= '0;
            rcon        <= 8'h00;
            key_assist  <= 1'b0;
            encryption  <= 1'b0;
            final_round <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dir         <= dir_n;
            op_valid    <= valid_n;
            op_kind     <= kind_n;
            round_idx   <= cnt_n;
            rcon        <= rcon_n;
            key_assist  <= key_assist_n;
            encryption  <= enc_n;
            final_round <= final_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: expected op streams are built from the round schedule.
module tb_aes_round_sequencer;

    localparam int N  = 10;
    localparam int IW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset, start, decrypt, abort, op_ready;
    logic          op_valid, key_assist, encryption, final_round, busy, done;
    logic [1:0]    op_kind;
    logic [IW-1:0] round_idx;
    logic [7:0]    rcon;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int idx;
        bit fin;
    } op_t;

    op_t exp_q[$];

    aes_round_sequencer #(.NUM_ROUNDS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .decrypt     (decrypt),
        .abort       (abort),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_kind     (op_kind),
        .round_idx   (round_idx),
        .rcon        (rcon),
        .key_assist  (key_assist),
        .encryption  (encryption),
        .final_round (final_round),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rcon as powers of two in GF(2^8): 2^(r-1), reduced past 0x80.
    function automatic int exp_rcon(input int r);
        if (r == 0) return 0;
        if (r <= 8) return 1 << (r - 1);
        if (r == 9) return 'h1b;
        return 'h36;
    endfunction

    function automatic void build(input bit dec);
        op_t o;
        exp_q.delete();
        if (!dec) begin
            o.kind = 0; o.idx = 0; o.fin = 0; exp_q.push_back(o);
            for (int r = 1; r <= N; r++) begin
                o.kind = 1; o.idx = r; o.fin = 0;        exp_q.push_back(o);
                o.kind = 2; o.idx = r; o.fin = (r == N); exp_q.push_back(o);
            end
        end else begin
            for (int r = 1; r <= N; r++) begin
                o.kind = 1; o.idx = r; o.fin = 0; exp_q.push_back(o);
            end
            o.kind = 0; o.idx = N; o.fin = 0; exp_q.push_back(o);
            for (int r = N - 1; r >= 0; r--) begin
                o.kind = 2; o.idx = r; o.fin = (r == 0); exp_q.push_back(o);
            end
        end
    endfunction

    function automatic int find_op(input bit dec, input int kind, input int idx);
        build(dec);
        foreach (exp_q[i]) if (exp_q[i].kind == kind && exp_q[i].idx == idx) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " op_valid"}, 32'(op_valid), 0);
        chk({tag, " op_kind"}, 32'(op_kind), 0);
        chk({tag, " round_idx"}, 32'(round_idx), 0);
        chk({tag, " rcon"}, 32'(rcon), 0);
        chk({tag, " key_assist"}, 32'(key_assist), 0);
        chk({tag, " encryption"}, 32'(encryption), 0);
        chk({tag, " final_round"}, 32'(final_round), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
    endtask

    // kill_kind: 0 none, 1 abort, 2 reset, applied while op kill_at is presented.
    task automatic run_seq(input bit dec, input bit rnd, input int stall_at, input int stall_len,
                           input int kill_at, input int kill_kind, input int extra_start,
                           input int exp_done);
        int  fires    = 0;
        int  stalled  = 0;
        int  k        = 0;
        bit  finished = 0;
        op_t e;
        build(dec);
        start    = 1'b1;
        decrypt  = dec;
        abort    = 1'b0;
        op_ready = 1'b1;
        step();
        k       = 1;
        start   = 1'b0;
        decrypt = 1'($urandom_range(0, 1));
        while (!finished && k < 400) begin
            chk("counter_bound", 32'(round_idx <= IW'(N)), 1);
            start = (k == extra_start);
            if (done) begin
                chk("done_fires", 32'(fires), 32'(2 * N + 1));
                if (exp_done > 0) chk("done_cycle", 32'(k), 32'(exp_done));
                chk("done_busy", 32'(busy), 1);
                chk("done_valid", 32'(op_valid), 0);
                start    = 1'b1;
                op_ready = 1'($urandom_range(0, 1));
                step();
                start = 1'b0;
                chk("after_done_busy", 32'(busy), 0);
                chk("after_done_done", 32'(done), 0);
                chk("after_done_valid", 32'(op_valid), 0);
                finished = 1;
            end else begin
                chk("busy_in_seq", 32'(busy), 1);
                if (fires >= exp_q.size()) begin
                    chk("valid_past_end", 32'(op_valid), 0);
                end else begin
                    chk("op_valid", 32'(op_valid), 1);
                    e = exp_q[fires];
                    chk("op_kind", 32'(op_kind), 32'(e.kind));
                    chk("round_idx", 32'(round_idx), 32'(e.idx));
                    chk("final_round", 32'(final_round), 32'(e.fin));
                    chk("key_assist", 32'(key_assist), 32'(e.kind == 1));
                    chk("encryption", 32'(encryption), 32'(!dec));
                    if (e.kind == 1) chk("rcon", 32'(rcon), 32'(exp_rcon(e.idx)));
                end
                if (fires == stall_at && stalled < stall_len) begin
                    op_ready = 1'b0;
                    stalled++;
                end else begin
                    op_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (op_valid && fires == kill_at && kill_kind != 0) begin
                    op_ready = 1'b1;
                    if (kill_kind == 1) abort = 1'b1;
                    else reset = 1'b1;
                    step();
                    abort = 1'b0;
                    reset = 1'b0;
                    if (kill_kind == 1) begin
                        chk("abort_busy", 32'(busy), 0);
                        chk("abort_valid", 32'(op_valid), 0);
                        chk("abort_done", 32'(done), 0);
                    end else begin
                        check_all_zero("midreset");
                    end
                    finished = 1;
                end else begin
                    if (op_valid && op_ready) fires++;
                    step();
                    k++;
                end
            end
        end
        if (!finished) chk("timeout", 0, 1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        decrypt  = 1'b0;
        abort    = 1'b0;
        op_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // abort beats start while idle
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("idle_abort_start_busy", 32'(busy), 0);
        chk("idle_abort_start_valid", 32'(op_valid), 0);

        run_seq(1'b0, 1'b0, -1, 0, -1, 0, -1, 2 * N + 2);
        run_seq(1'b1, 1'b0, -1, 0, -1, 0, -1, 2 * N + 2);
        run_seq(1'b0, 1'b0, find_op(1'b0, 1, 4), 3, -1, 0, -1, 2 * N + 5);
        run_seq(1'b0, 1'b0, -1, 0, find_op(1'b0, 2, 5), 1, -1, 0);
        run_seq(1'b0, 1'b0, -1, 0, -1, 0, 5, 2 * N + 2);
        run_seq(1'b0, 1'b0, -1, 0, find_op(1'b0, 2, 3), 2, -1, 0);
        run_seq(1'b1, 1'b0, -1, 0, -1, 0, -1, 2 * N + 2);
        for (int i = 0; i < 6; i++) begin
            run_seq(1'($urandom_range(0, 1)), 1'b1, -1, 0, -1, 0, int'($urandom_range(2, 30)), 0);
        end
        run_seq(1'b1, 1'b1, -1, 0, find_op(1'b1, 2, 4), 1, -1, 0);
        run_seq(1'b1, 1'b0, -1, 0, -1, 0, -1, 2 * N + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
